// File: rtl/chaser_pkg.sv
// Shared types and constants for the rotating pattern chaser.
package chaser_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic       DIR_LEFT  = 1'b0;
    localparam logic       DIR_RIGHT = 1'b1;
    localparam logic [1:0] LEG_LAST  = 2'd2;

endpackage

// File: rtl/rotate_chaser_if.sv
// Control and status bundle of the chaser; master is the controller, slave the chaser.
// Handshake: no valid/ready pair; tick is the single-cycle strobe that marks a new pattern.
interface rotate_chaser_if #(
    parameter int DIV_W = 8
);
    import chaser_pkg::*;

    logic             load;
    logic [3:0]       load_pat;
    logic             dir_in;
    logic [1:0]       step;
    logic             bounce;
    logic [DIV_W-1:0] div;
    logic             start;
    logic             stop;
    logic [3:0]       pattern;
    logic             dir_out;
    logic             tick;
    logic             running;
    state_t           state;

    modport master (
        output load, load_pat, dir_in, step, bounce, div, start, stop,
        input  pattern, dir_out, tick, running, state
    );

    modport slave (
        input  load, load_pat, dir_in, step, bounce, div, start, stop,
        output pattern, dir_out, tick, running, state
    );

endinterface

// File: rtl/barrel_shifter.sv
// 4-bit combinational rotator: dir 0 rotates left, dir 1 rotates right, by s places.
module barrel_shifter (
    input  logic [3:0] d,
    input  logic [1:0] s,
    input  logic       dir,
    output logic [3:0] y
);

    always_comb begin
        y = d;
        case (s)
            2'd1: y = dir ? {d[0],   d[3:1]} : {d[2:0], d[3]};
            2'd2: y = {d[1:0], d[3:2]};
            2'd3: y = dir ? {d[2:0], d[3]}   : {d[0],   d[3:1]};
            default: y = d;
        endcase
    end

endmodule

// File: rtl/rotate_chaser.sv
// Pattern chaser: a prescaled tick writes the rotator output back into the pattern register,
// with optional ping-pong direction reversal every three rotations.
module rotate_chaser
    import chaser_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    rotate_chaser_if.slave bus
);

    state_t           state;
    logic [3:0]       pattern;
    logic             dir_r;
    logic             tick_r;
    logic [DIV_W-1:0] presc;
    logic [1:0]       leg;
    logic [3:0]       rotated;

    barrel_shifter u_shifter (
        .d   (pattern),
        .s   (bus.step),
        .dir (dir_r),
        .y   (rotated)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pattern <= 4'b0000;
            dir_r   <= DIR_LEFT;
            tick_r  <= 1'b0;
            presc   <= '0;
            leg     <= 2'd0;
        end else if (bus.load) begin
            pattern <= bus.load_pat;
            dir_r   <= bus.dir_in;
            presc   <= '0;
            leg     <= 2'd0;
            tick_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tick_r <= 1'b0;
                    if (bus.start && !bus.stop) begin
                        state <= RUN;
                        presc <= '0;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state  <= IDLE;
                        tick_r <= 1'b0;
                    end else begin
                        if (!bus.bounce) begin
                            leg <= 2'd0;
                        end
                        // >= so a live decrease of div cannot strand presc above it
                        if (presc >= bus.div) begin
                            pattern <= rotated;
                            tick_r  <= 1'b1;
                            presc   <= '0;
                            if (bus.bounce) begin
                                if (leg == LEG_LAST) begin
                                    leg   <= 2'd0;
                                    dir_r <= ~dir_r;
                                end else begin
                                    leg <= leg + 2'd1;
                                end
                            end
                        end else begin
                            presc  <= presc + 1'b1;
                            tick_r <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pattern = pattern;
    assign bus.dir_out = dir_r;
    assign bus.tick    = tick_r;
    assign bus.running = (state == RUN);
    assign bus.state   = state;

endmodule

// File: tb/tb_rotate_chaser.sv
// Directed bench for rotate_chaser: expected ticks are queued with their cycle stamp,
// a negedge monitor pops one per observed tick.
module tb_rotate_chaser;
    import chaser_pkg::*;

    localparam int W = 21;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   t;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e;
    logic [15:0]  mon_c;

    rotate_chaser_if #(.DIV_W(8)) bus();

    rotate_chaser #(.DIV_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic d, input logic [3:0] p);
        logic [15:0] cs;
        cs = c[15:0];
        exp_q.push_back({cs, d, p});
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic load_cfg(input logic [3:0] p, input logic d, input logic [1:0] s,
                            input logic [7:0] dv);
        bus.load     = 1'b1;
        bus.load_pat = p;
        bus.dir_in   = d;
        bus.step     = s;
        bus.div      = dv;
        @(negedge clk);
        bus.load = 1'b0;
        check("load_pattern", {17'd0, bus.pattern}, {17'd0, p});
        check("load_dir", {20'd0, bus.dir_out}, {20'd0, d});
    endtask

    // monitor: every tick must match the head of the expected queue
    always @(negedge clk) begin
        if (bus.tick === 1'b1) begin
            mon_c = cyc[15:0];
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tick: got pattern %b dir %b expected no tick at cycle %0d",
                         bus.pattern, bus.dir_out, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("tick_cycle_dir_pattern", {mon_c, bus.dir_out, bus.pattern}, mon_e);
            end
        end
    end

    initial begin
        bus.load = 1'b1;  bus.load_pat = 4'hF;  bus.dir_in = 1'b1;
        bus.step = 2'd1;  bus.bounce = 1'b0;    bus.div = 8'd0;
        bus.start = 1'b1; bus.stop = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_pattern", {17'd0, bus.pattern}, '0);
        check("reset_dir", {20'd0, bus.dir_out}, '0);
        check("reset_running", {20'd0, bus.running}, '0);
        check("reset_tick", {20'd0, bus.tick}, '0);
        rst_n = 1'b1; bus.load = 1'b0; bus.start = 1'b0;
        @(negedge clk);

        // left chase, div 0: a new pattern every cycle, then stop on a would-be tick
        load_cfg(4'b0001, DIR_LEFT, 2'd1, 8'd0);
        t = cyc;
        bus.start = 1'b1;
        push(t + 2, 1'b0, 4'b0010);
        push(t + 3, 1'b0, 4'b0100);
        push(t + 4, 1'b0, 4'b1000);
        push(t + 5, 1'b0, 4'b0001);
        @(negedge clk);
        bus.start = 1'b0;
        check("running_after_start", {20'd0, bus.running}, 21'd1);
        wait_to(t + 5);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        check("stop_running", {20'd0, bus.running}, '0);
        check("stop_tick", {20'd0, bus.tick}, '0);
        check("stop_frozen", {17'd0, bus.pattern}, 21'b0001);
        repeat (2) @(negedge clk);
        check("stop_still_frozen", {17'd0, bus.pattern}, 21'b0001);

        // start and stop together in IDLE
        bus.start = 1'b1; bus.stop = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.stop = 1'b0;
        check("start_stop_idle", {20'd0, bus.running}, '0);

        // divider: div 3, right by 2
        load_cfg(4'b1100, DIR_RIGHT, 2'd2, 8'd3);
        t = cyc;
        bus.start = 1'b1;
        push(t + 5, 1'b1, 4'b0011);
        push(t + 9, 1'b1, 4'b1100);
        @(negedge clk);
        bus.start = 1'b0;
        wait_to(t + 6);
        check("div_tick_pulse", {20'd0, bus.tick}, '0);
        wait_to(t + 9);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;

        // bounce: three rotations per leg
        bus.bounce = 1'b1;
        load_cfg(4'b0001, DIR_LEFT, 2'd1, 8'd0);
        t = cyc;
        bus.start = 1'b1;
        push(t + 2, 1'b0, 4'b0010);
        push(t + 3, 1'b0, 4'b0100);
        push(t + 4, 1'b1, 4'b1000);
        push(t + 5, 1'b1, 4'b0100);
        push(t + 6, 1'b1, 4'b0010);
        push(t + 7, 1'b0, 4'b0001);
        push(t + 8, 1'b0, 4'b0010);
        @(negedge clk);
        bus.start = 1'b0;
        wait_to(t + 8);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        bus.bounce = 1'b0;

        // load on a tick cycle wins over the rotation
        load_cfg(4'b0001, DIR_LEFT, 2'd1, 8'd0);
        t = cyc;
        bus.start = 1'b1;
        push(t + 2, 1'b0, 4'b0010);
        push(t + 4, 1'b0, 4'b0101);
        @(negedge clk);
        bus.start = 1'b0;
        wait_to(t + 2);
        bus.load = 1'b1; bus.load_pat = 4'b1010; bus.dir_in = DIR_LEFT;
        @(negedge clk);
        bus.load = 1'b0;
        check("load_wins_pattern", {17'd0, bus.pattern}, 21'b1010);
        check("load_wins_tick", {20'd0, bus.tick}, '0);
        check("load_keeps_run", {20'd0, bus.running}, 21'd1);
        wait_to(t + 4);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;

        // reset mid-run
        load_cfg(4'b0101, DIR_RIGHT, 2'd1, 8'd0);
        t = cyc;
        bus.start = 1'b1;
        push(t + 2, 1'b1, 4'b1010);
        @(negedge clk);
        bus.start = 1'b0;
        wait_to(t + 2);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrun_reset_pattern", {17'd0, bus.pattern}, '0);
        check("midrun_reset_dir", {20'd0, bus.dir_out}, '0);
        check("midrun_reset_running", {20'd0, bus.running}, '0);
        check("midrun_reset_tick", {20'd0, bus.tick}, '0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        check("queue_drained", exp_q.size(), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
